cache_refill_controller: RTL and testbench

- Miss handler between the data cache and main memory.
- Accepts a miss from the cache and writes back the dirty victim line, if any, as a word burst.
- Fetches the missing line as a word burst, then presents the whole line to the cache in a one-cycle fill strobe.
- Holds the CPU pipeline stalled for the whole operation.

---
 rtl/cache_refill_controller.sv | 144 ++++++++++++++
 tb/tb_cache_refill_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_controller.sv
// Data-cache miss handler: writes back a dirty victim line as a word burst,
// fetches the missing line as a word burst, then delivers it to the cache
// in a single fill strobe while holding the pipeline stalled.
module cache_refill_controller #(
    parameter int WIDTH      = 32,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [WIDTH-1:0]        miss_addr,
    input  logic                    wb_dirty,
    input  logic [WIDTH-1:0]        wb_addr,
    input  logic [BLOCK_SIZE*8-1:0] wb_data,
    output logic                    stall,
    output logic                    fill_valid,
    output logic [WIDTH-1:0]        fill_addr,
    output logic [BLOCK_SIZE*8-1:0] fill_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [WIDTH-1:0]        mem_addr,
    output logic [WIDTH-1:0]        mem_wdata,
    input  logic                    mem_ack,
    input  logic [WIDTH-1:0]        mem_rdata
);

    localparam int BYTES_PER_WORD = WIDTH / 8;
    localparam int BEATS          = BLOCK_SIZE / BYTES_PER_WORD;
    localparam int CNT_W          = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W          = $clog2(BLOCK_SIZE);
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam int LINE_W         = BLOCK_SIZE * 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_FILL  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  beat_cnt;
    logic [WIDTH-1:0]  base_addr;
    logic [WIDTH-1:0]  victim_addr;
    logic [LINE_W-1:0] victim_line;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_merged;
    logic [WIDTH-1:0]  beat_offset;
    logic              beat_done;
    logic              last_beat;

    assign beat_offset = WIDTH'(beat_cnt) << WORD_SHIFT;
    assign beat_done   = mem_req && mem_ack;
    assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));

    // Next-state selection; a beat only advances when memory acks it.
    // NOTE: every signal assigned in always_comb gets a default first, otherwise an unassigned path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (miss_req) state_next = wb_dirty ? S_WB : S_FETCH;
            S_WB:    if (beat_done && last_beat) state_next = S_FETCH;
            S_FETCH: if (beat_done && last_beat) state_next = S_FILL;
            S_FILL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore-style outputs, except stall which follows miss_req in IDLE so the miss cycle itself is frozen.
    always_comb begin
        stall      = 1'b1;
        fill_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: stall = miss_req && !rst;
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = victim_addr + beat_offset;
                mem_wdata = victim_line[beat_cnt*WIDTH +: WIDTH];
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = base_addr + beat_offset;
            end
            S_FILL:  fill_valid = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Line buffer with the current read beat merged in, used both for the buffer and the final fill.
    always_comb begin
        line_merged = line_buf;
        line_merged[beat_cnt*WIDTH +: WIDTH] = mem_rdata;
    end

    // State register and beat counter; the counter restarts on every state change.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                beat_cnt <= '0;
            end else if (beat_done) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Capture the miss context in IDLE; later changes on the cache side are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_addr   <= '0;
            victim_addr <= '0;
            victim_line <= '0;
        end else if (state == S_IDLE && miss_req) begin
            base_addr   <= {miss_addr[WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            victim_addr <= wb_addr;
            victim_line <= wb_data;
        end
    end

    // Assemble fetched words; the fill outputs are loaded on the last ack and then held until the next refill.
    // NOTE: the line buffer is reset so a fetch aborted by reset can never leak words into a later fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_buf  <= '0;
            fill_addr <= '0;
            fill_data <= '0;
        end else if (state == S_FETCH && beat_done) begin
            line_buf <= line_merged;
            if (last_beat) begin
                fill_addr <= base_addr;
                fill_data <= line_merged;
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Self-checking bench for cache_refill_controller (Width=32, BlockSize=16).
// A table of refill scenarios drives a memory responder; expected beats and
// fills are queued when a miss is issued and popped as the DUT produces them.
module tb_cache_refill_controller;

    localparam int BEATS = 4;

    logic         clk;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         wb_dirty;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic         stall;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    cache_refill_controller #(.WIDTH(32), .BLOCK_SIZE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .wb_dirty   (wb_dirty),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .stall      (stall),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } fill_t;

    typedef struct {
        logic         dirty;
        logic [31:0]  miss_addr;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        int           ack_period;
        logic         spurious;
        logic [31:0]  salt;
        int           exp_stall;
    } refill_t;

    beat_t   exp_beats[$];
    fill_t   exp_fills[$];
    refill_t vec[4];

    int n_checks = 0;
    int n_err    = 0;

    // responder / monitor state
    int          ack_period;
    logic        spurious;
    logic [31:0] salt;
    int          wait_cnt;
    int          cyc;
    int          stall_cnt;
    int          fill_cnt;
    int          fill_cyc;
    int          first_fill_cyc;
    int          rd_req_cyc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue the beats and fill a refill is required to produce.
    task automatic push_expect(input logic dirty, input logic [31:0] m_addr, input logic [31:0] v_addr,
                               input logic [127:0] v_data, input logic [31:0] s);
        logic [31:0]  base;
        logic [127:0] line;
        beat_t        b;
        fill_t        f;
        base = m_addr & ~32'hF;
        line = '0;
        if (dirty) begin
            for (int i = 0; i < BEATS; i++) begin
                b.we = 1'b1; b.addr = v_addr + 32'(4 * i); b.wdata = v_data[32*i +: 32];
                exp_beats.push_back(b);
            end
        end
        for (int i = 0; i < BEATS; i++) begin
            b.we = 1'b0; b.addr = base + 32'(4 * i); b.wdata = '0;
            exp_beats.push_back(b);
            line[32*i +: 32] = (base + 32'(4 * i)) ^ s;
        end
        f.addr = base; f.data = line;
        exp_fills.push_back(f);
    endtask

    task automatic clear_counters();
        cyc = 0; stall_cnt = 0; fill_cnt = 0; fill_cyc = 0;
        first_fill_cyc = 0; rd_req_cyc = 0; wait_cnt = 0;
    endtask

    // One clock cycle: sample settled outputs, score them, drive the memory response.
    task automatic step();
        beat_t b;
        fill_t f;
        @(negedge clk);
        #1;
        cyc++;
        if (stall) stall_cnt++;
        if (mem_req) begin
            if (!mem_we) rd_req_cyc++;
            mem_ack = (wait_cnt == ack_period - 1);
            wait_cnt = mem_ack ? 0 : wait_cnt + 1;
            mem_rdata = mem_ack ? (mem_addr ^ salt) : 32'hDEAD_BEEF;
            if (exp_beats.size() == 0) begin
                check("beat_unexpected", 1, 0);
            end else begin
                b = exp_beats[0];
                check("beat_we", mem_we, b.we);
                check("beat_addr", mem_addr, b.addr);
                if (b.we) check("beat_wdata", mem_wdata, b.wdata);
                if (mem_ack) void'(exp_beats.pop_front());
            end
        end else begin
            mem_ack   = spurious;
            mem_rdata = 32'hBAD0_BAD0;
        end
        if (fill_valid) begin
            fill_cnt++;
            if (fill_cnt == 1) first_fill_cyc = cyc;
            fill_cyc = cyc;
            if (exp_fills.size() == 0) begin
                check("fill_unexpected", 1, 0);
            end else begin
                f = exp_fills.pop_front();
                check("fill_addr", fill_addr, f.addr);
                check("fill_data", fill_data, f.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one miss, scramble the cache-side inputs afterwards, run until one cycle past the fill.
    task automatic run_refill(input refill_t r);
        ack_period = r.ack_period;
        spurious   = r.spurious;
        salt       = r.salt;
        clear_counters();
        push_expect(r.dirty, r.miss_addr, r.wb_addr, r.wb_data, r.salt);
        for (int c = 1; c <= 200; c++) begin
            if (c == 1) begin
                miss_req = 1'b1; miss_addr = r.miss_addr; wb_dirty = r.dirty;
                wb_addr = r.wb_addr; wb_data = r.wb_data;
            end else begin
                miss_req = 1'b0; miss_addr = $urandom; wb_dirty = 1'($urandom);
                wb_addr = $urandom; wb_data = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            if (fill_cnt > 0 && cyc == fill_cyc + 1) break;
        end
        check("fill_count", fill_cnt, 1);
        check("fill_cycle", fill_cyc, r.exp_stall);
        check("stall_cycles", stall_cnt, r.exp_stall);
        check("read_req_cycles", rd_req_cyc, BEATS * r.ack_period);
        check("beats_left", exp_beats.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_fill_valid"}, fill_valid, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_fill_addr"}, fill_addr, 0);
        check({tag, "_fill_data"}, fill_data, 0);
    endtask

    initial begin
        vec[0] = '{1'b0, 32'h0000_1234, 32'h0, 128'h0, 1, 1'b0, 32'h0, 6};
        vec[1] = '{1'b1, 32'h0000_1000, 32'h0000_4000,
                   128'h0F0E0D0C_0B0A0908_07060504_03020100, 1, 1'b0, 32'h0, 10};
        vec[2] = '{1'b0, 32'h0000_5678, 32'h0, 128'h0, 3, 1'b0, 32'hA5A5_0000, 14};
        vec[3] = '{1'b1, 32'h0000_ABCD, 32'h0000_8F30,
                   128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE, 2, 1'b1, 32'h3C3C_0000, 18};

        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; wb_dirty = 1'b0;
        wb_addr = '0; wb_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        ack_period = 1; spurious = 1'b0; salt = '0;
        clear_counters();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_refill(vec[i]);

        // Reset mid-FETCH after 2 of 4 read beats.
        ack_period = 1; spurious = 1'b0; salt = 32'h7700_0000;
        clear_counters();
        push_expect(1'b0, 32'h0000_7000, 32'h0, 128'h0, salt);
        miss_req = 1'b1; miss_addr = 32'h0000_7000; wb_dirty = 1'b0;
        step();
        miss_req = 1'b0;
        step();
        step();
        check("pre_reset_mem_addr", mem_addr, 32'h0000_7008);
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk);
        #1;
        check("reset_held_mem_req", mem_req, 0);
        rst = 1'b0; mem_ack = 1'b0;
        exp_beats.delete();
        exp_fills.delete();
        run_refill('{1'b0, 32'h0000_2000, 32'h0, 128'h0, 1, 1'b0, 32'h5A00_0000, 6});

        // Back-to-back misses: miss_req held through FILL, new address 0x3000.
        ack_period = 1; spurious = 1'b0; salt = 32'h0F0F_0000;
        clear_counters();
        push_expect(1'b0, 32'h0000_6000, 32'h0, 128'h0, salt);
        push_expect(1'b0, 32'h0000_3000, 32'h0, 128'h0, salt);
        for (int c = 1; c <= 60; c++) begin
            miss_req  = (c <= 7);
            miss_addr = (c == 1) ? 32'h0000_6000 : 32'h0000_3000;
            wb_dirty  = 1'b0;
            step();
            if (fill_cnt == 2 && cyc == fill_cyc + 1) break;
        end
        check("b2b_fill_count", fill_cnt, 2);
        check("b2b_first_fill", first_fill_cyc, 6);
        check("b2b_second_fill", fill_cyc, 12);
        check("b2b_stall_cycles", stall_cnt, 12);
        check("b2b_beats_left", exp_beats.size(), 0);
        check("b2b_hold_fill_addr", fill_addr, 32'h0000_3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
